// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Transmit-side serializer for the 16750-compatible UART. Takes
//            one character and shifts it out on SOUT as a start bit, 5-8 data
//            bits (LSB first), optional parity and 1 / 1.5 / 2 stop bits.
//            Bit timing comes from the 16x baud enable pulse TXCLK.
// Ports    :
//   CLK        in   system clock
//   RST        in   asynchronous active-high reset
//   TXCLK      in   single-CLK oversampling baud enable pulse
//   CLEAR      in   synchronous abort, returns to idle
//   TXSTART    in   send request, accepted only while idle
//   DIN[7:0]   in   character to send (unused upper bits ignored)
//   WLS[1:0]   in   word length 00=5 .. 11=8
//   STB        in   0 = 1 stop bit, 1 = 2 stop bits (1.5 when WLS=00)
//   PEN        in   parity enable
//   EPS        in   even parity select
//   SP         in   stick parity
//   BC         in   break control, forces SOUT low
//   BUSY       out  high whenever the state is not idle
//   TXFINISHED out  one-CLK pulse when the last stop bit ends
//   SOUT       out  serial output, idles high
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TXCLK,
    input  logic       CLEAR,
    input  logic       TXSTART,
    input  logic [7:0] DIN,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    output logic       BUSY,
    output logic       TXFINISHED,
    output logic       SOUT
);

    localparam int c_tick_w = $clog2(OVERSAMPLE);
    localparam logic [c_tick_w-1:0] c_tick_full = c_tick_w'(OVERSAMPLE - 1);
    // Half a bit period, used for the 1.5 stop bit case.
    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_tick_w-1:0]   r_tick;
    logic [2:0]            r_bitcnt;
    logic [7:0]            r_shift;     // character latched at frame start
    logic [1:0]            r_wls;
    logic                  r_stb;
    logic                  r_pen;
    logic                  r_eps;
    logic                  r_sp;
    logic                  r_sout;
    logic                  r_busy;
    logic                  r_fin;

    // ------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [c_tick_w-1:0]   w_tick_nxt;
    logic [2:0]            w_bitcnt_nxt;
    logic                  w_fin_nxt;
    logic                  w_load;
    logic                  w_sout_nxt;
    logic [c_tick_w-1:0]   w_tick_last;
    logic                  w_bit_end;
    logic [2:0]            w_last_bit;
    logic [7:0]            w_mask;
    logic                  w_parity;

    // STOP2 is only half a bit long for 5-bit words (1.5 stop bits).
    assign w_tick_last = (r_state == S_STOP2 && r_wls == 2'b00) ? c_tick_half : c_tick_full;
    assign w_bit_end   = TXCLK && (r_tick == w_tick_last);
    assign w_last_bit  = {1'b0, r_wls} + 3'd4;

    always_comb begin
        w_mask = 8'hFF;
        case (r_wls)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    // Stick parity transmits the inverse of EPS; otherwise even parity is the
    // XOR of the active data bits and odd parity its complement.
    always_comb begin
        w_parity = 1'b1;
        if (r_sp) begin
            w_parity = ~r_eps;
        end else if (r_eps) begin
            w_parity = ^(r_shift & w_mask);
        end else begin
            w_parity = ~^(r_shift & w_mask);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_bitcnt_nxt = r_bitcnt;
        w_fin_nxt    = 1'b0;
        w_load       = 1'b0;

        if (CLEAR) begin
            // Abort wins over everything, including a pending start.
            w_state_nxt  = S_IDLE;
            w_tick_nxt   = '0;
            w_bitcnt_nxt = 3'd0;
        end else begin
            if (r_state != S_IDLE && TXCLK) begin
                w_tick_nxt = w_bit_end ? '0 : r_tick + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (TXSTART) begin
                        w_load       = 1'b1;
                        w_state_nxt  = S_START;
                        w_tick_nxt   = '0;
                        w_bitcnt_nxt = 3'd0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        w_state_nxt  = S_DATA;
                        w_bitcnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == w_last_bit) begin
                            w_state_nxt  = r_pen ? S_PARITY : S_STOP1;
                            w_bitcnt_nxt = 3'd0;
                        end else begin
                            w_bitcnt_nxt = r_bitcnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        w_state_nxt = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (w_bit_end) begin
                        if (r_stb) begin
                            w_state_nxt = S_STOP2;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_fin_nxt   = 1'b1;
                        end
                    end
                end
                S_STOP2: begin
                    if (w_bit_end) begin
                        w_state_nxt = S_IDLE;
                        w_fin_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_tick_nxt   = '0;
                    w_bitcnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // Line level for the state being entered, so SOUT is a clean register.
    // The start bit never depends on the latched data, so it does not matter
    // that r_shift is only loaded on the accepting edge.
    always_comb begin
        w_sout_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_sout_nxt = 1'b0;
            S_DATA:   w_sout_nxt = r_shift[w_bitcnt_nxt];
            S_PARITY: w_sout_nxt = w_parity;
            default:  w_sout_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_wls    <= 2'b00;
            r_stb    <= 1'b0;
            r_pen    <= 1'b0;
            r_eps    <= 1'b0;
            r_sp     <= 1'b0;
            r_sout   <= 1'b1;
            r_busy   <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            if (w_load) begin
                // Line control is frozen for the whole frame.
                r_shift <= DIN;
                r_wls   <= WLS;
                r_stb   <= STB;
                r_pen   <= PEN;
                r_eps   <= EPS;
                r_sp    <= SP;
            end
            r_sout   <= w_sout_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_fin    <= w_fin_nxt;
        end
    end

    // Break overrides the line without disturbing the frame in progress.
    assign SOUT       = r_sout & ~BC;
    assign BUSY       = r_busy;
    assign TXFINISHED = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Self-checking bench for uart_tx_serializer. Directed frames push
//            their hand-computed bit sequence and length into a scoreboard;
//            an independent monitor samples SOUT mid-bit and checks frame end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic       CLK;
    logic       RST;
    logic       TXCLK;
    logic       CLEAR;
    logic       TXSTART;
    logic [7:0] DIN;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic       BUSY;
    logic       TXFINISHED;
    logic       SOUT;

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TXCLK      (TXCLK),
        .CLEAR      (CLEAR),
        .TXSTART    (TXSTART),
        .DIN        (DIN),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .BC         (BC),
        .BUSY       (BUSY),
        .TXFINISHED (TXFINISHED),
        .SOUT       (SOUT)
    );

    typedef struct {
        logic [15:0] bits;     // first transmitted bit is bits[nbits-1]
        int          nbits;    // mid-bit samples expected
        int          npulses;  // TXCLK pulses from accept to TXFINISHED
        bit          abort;    // frame is expected to end without TXFINISHED
        int          tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   g_pulse = 0;
    int   p0 = 0;
    bit   txclk_en = 1'b1;
    bit   in_frame = 1'b0;
    int   mon_pulses = 0;
    int   mon_samples = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One TXCLK pulse every three CLK cycles.
    initial begin
        int div;
        div   = 0;
        TXCLK = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (txclk_en && div == 0) begin
                TXCLK = 1'b1;
                g_pulse++;
            end else begin
                TXCLK = 1'b0;
            end
            div = (div + 1) % 3;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops the expected frame when BUSY rises, samples SOUT in the
    // middle of each bit, and checks the way and the time the frame ends.
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        if (in_frame && !BUSY) begin
            chk($sformatf("frame%0d_end_abort", cur.tag), {31'd0, !TXFINISHED}, {31'd0, cur.abort});
            if (!cur.abort && TXFINISHED) begin
                chk($sformatf("frame%0d_pulses", cur.tag), mon_pulses, cur.npulses);
                chk($sformatf("frame%0d_samples", cur.tag), mon_samples, cur.nbits);
            end
            in_frame = 1'b0;
        end else if (!in_frame && TXFINISHED) begin
            chk("spurious_txfinished", {31'd0, TXFINISHED}, 32'd0);
        end

        if (!in_frame && BUSY) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame", {31'd0, BUSY}, 32'd0);
                cur.bits = '0; cur.nbits = 0; cur.npulses = 0; cur.abort = 1'b1; cur.tag = -1;
            end else begin
                cur = sb.pop_front();
            end
            in_frame    = 1'b1;
            mon_pulses  = 0;
            mon_samples = 0;
        end

        if (in_frame && TXCLK) begin
            if (mon_pulses % 16 == 8) begin
                int idx;
                idx = mon_pulses / 16;
                if (idx < cur.nbits) begin
                    chk($sformatf("frame%0d_bit%0d", cur.tag, idx), {31'd0, SOUT},
                        {31'd0, cur.bits[cur.nbits - 1 - idx]});
                end
                mon_samples++;
            end
            mon_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input logic [15:0] bits, input int nbits, input int np,
                            input bit ab, input int tag);
        exp_t e;
        e.bits = bits; e.nbits = nbits; e.npulses = np; e.abort = ab; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                        input logic pen, input logic eps, input logic sp,
                        input logic [15:0] bits, input int nbits, input int np,
                        input bit ab, input int tag);
        @(posedge CLK); #1;
        DIN = din; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
        push_exp(bits, nbits, np, ab, tag);
        TXSTART = 1'b1;
        @(posedge CLK); #1;
        TXSTART = 1'b0;
        // Scramble the config so the frame must rely on its latched copy.
        DIN = ~din; WLS = ~wls; STB = ~stb; PEN = ~pen; EPS = ~eps; SP = ~sp;
        p0 = g_pulse;
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while ((g_pulse - p0) < n && k < 5000) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 5000) chk("wait_pulses_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge CLK);
        while (BUSY && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 3000) chk("wait_done_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int k;
        RST = 1'b1; CLEAR = 1'b0; TXSTART = 1'b0; DIN = 8'h00; WLS = 2'b11;
        STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_sout", {31'd0, SOUT}, 32'd1);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_txfinished", {31'd0, TXFINISHED}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // 8N1 0x55, with a TXCLK stall in data bit 0 (line level 1).
        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0101010101, 10, 160, 1'b0, 1);
        wait_pulses(24);
        txclk_en = 1'b0;
        repeat (60) @(posedge CLK);
        @(negedge CLK);
        chk("stall_sout", {31'd0, SOUT}, 32'd1);
        chk("stall_busy", {31'd0, BUSY}, 32'd1);
        @(posedge CLK); #1;
        txclk_en = 1'b1;
        wait_done();

        // 7E1 / 7O1, DIN=0x83: data 0000011, bit 7 never sent.
        send(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 16'b0110000001, 10, 160, 1'b0, 2);
        wait_done();
        send(8'h83, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'b0110000011, 10, 160, 1'b0, 3);
        wait_done();

        // Stick parity, 8 bits.
        send(8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 16'b00000000001, 11, 176, 1'b0, 4);
        wait_done();
        send(8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 16'b01111111101, 11, 176, 1'b0, 5);
        wait_done();
        send(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 16'b00000000011, 11, 176, 1'b0, 6);
        wait_done();
        send(8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 16'b01111111111, 11, 176, 1'b0, 7);
        wait_done();

        // 5 bits + 1.5 stop: DIN=0xF3 -> 10011, frame 120 pulses.
        send(8'hF3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'b0110011, 7, 120, 1'b0, 8);
        wait_done();
        // 8N2, DIN=0x0F, frame 176 pulses.
        send(8'h0F, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 16'b01111000011, 11, 176, 1'b0, 9);
        wait_done();

        // Back-to-back with TXSTART held high: 0xA5 then 0x3C.
        @(posedge CLK); #1;
        DIN = 8'hA5; WLS = 2'b11; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
        push_exp(16'b0101001011, 10, 160, 1'b0, 10);
        TXSTART = 1'b1;
        @(posedge CLK); #1;
        DIN = 8'h3C;
        push_exp(16'b0001111001, 10, 160, 1'b0, 11);
        k = 0;
        @(negedge CLK);
        while (!TXFINISHED && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 3000) chk("b2b_finish_timeout", 32'd1, 32'd0);
        @(posedge CLK); #1;
        TXSTART = 1'b0;
        @(negedge CLK);
        chk("b2b_second_busy", {31'd0, BUSY}, 32'd1);
        chk("b2b_second_start", {31'd0, SOUT}, 32'd0);
        wait_done();

        // Break during data bits 2..3 of 0xFF; frame timing unchanged.
        send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0110011111, 10, 160, 1'b0, 12);
        wait_pulses(50);
        BC = 1'b1;
        #1;
        chk("break_sout_now", {31'd0, SOUT}, 32'd0);
        wait_pulses(78);
        BC = 1'b0;
        wait_done();

        // CLEAR during the parity bit of a 7E1 frame.
        send(8'h83, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 16'b0110000001, 10, 160, 1'b1, 13);
        wait_pulses(132);
        CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        @(negedge CLK);
        chk("clear_sout", {31'd0, SOUT}, 32'd1);
        chk("clear_busy", {31'd0, BUSY}, 32'd0);
        chk("clear_txfinished", {31'd0, TXFINISHED}, 32'd0);
        wait_done();

        // Asynchronous reset mid-frame.
        send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'b0000000001, 10, 160, 1'b1, 14);
        wait_pulses(40);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_sout", {31'd0, SOUT}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_txfinished", {31'd0, TXFINISHED}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("final_idle_busy", {31'd0, BUSY}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side serializer for the 16750-compatible UART; the counterpart of the receive deserializer.
- Takes one character from the TX holding register/FIFO and shifts it out on SOUT as start, 5-8 data bits (LSB first), optional parity, and 1/1.5/2 stop bits.
- Bit timing comes from the 16x baud-rate enable pulse TXCLK, produced by the baud generator in the same clock domain.
- Line-control fields come straight from the LCR.

Parameters:
- OVERSAMPLE, 16, TXCLK pulses per bit period (power of two, 8..16).

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-high
- TXCLK  input  1  single-CLK 16x baud enable pulse
- CLEAR  input  1  synchronous abort; return to idle
- TXSTART  input  1  request to send DIN; accepted only in IDLE
- DIN  input  8  character to send; unused upper bits ignored
- WLS  input  2  word length: 00=5, 01=6, 10=7, 11=8
- STB  input  1  0=1 stop bit; 1=2 stop bits (1.5 when WLS=00)
- PEN  input  1  parity enable
- EPS  input  1  even parity select
- SP  input  1  stick parity
- BC  input  1  break control; forces SOUT low
- BUSY  output  1  high whenever state is not IDLE
- TXFINISHED  output  1  one-CLK pulse when the last stop bit ends
- SOUT  output  1  serial output, idle high

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: state IDLE, SOUT=1, BUSY=0, TXFINISHED=0, tick counter 0, bit counter 0, shift register 0.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- All outputs are registered.
- Frame acceptance:
  - IDLE with TXSTART=1: on that edge, latch DIN, WLS, STB, PEN, EPS and SP into internal registers, clear the tick counter, go to START.
  - SOUT=0 from the next cycle.
  - Config changes mid-frame do not affect the current frame.
- Bit timing:
  - The tick counter increments only on cycles with TXCLK=1.
  - A bit period ends on the TXCLK pulse where tick=OVERSAMPLE-1. That pulse clears the counter and advances the state or bit.
  - Each bit therefore lasts exactly OVERSAMPLE TXCLK pulses.
  - The 1.5-stop case ends STOP2 at tick=OVERSAMPLE/2-1.
- START: SOUT=0. Then go to DATA with bit count 0.
- DATA:
  - SOUT = latched data[bitcnt].
  - After bit WLS+4 completes, go to PARITY if PEN=1, else STOP1.
- PARITY: SOUT is computed from the latched data bits only (unused bits masked):
  - SP=1: SOUT = ~EPS.
  - SP=0, EPS=1: SOUT = XOR of data bits (even parity).
  - SP=0, EPS=0: SOUT = XNOR of data bits (odd parity).
- STOP1: SOUT=1. Then go to STOP2 if STB=1, else IDLE.
- STOP2: SOUT=1. Length is a full bit, or half a bit when WLS=00. Then go to IDLE.
- Completion:
  - TXFINISHED is high for exactly the first CLK cycle in which the state is IDLE after a frame.
  - TXSTART in that same cycle is accepted, giving back-to-back frames with no idle gap.
- TXSTART while BUSY=1 is ignored: no queuing, no corruption.
- Break:
  - BC=1 forces SOUT=0 combinationally over the registered value, in any state.
  - The FSM keeps running, and TXFINISHED still pulses normally.
  - When BC drops, SOUT resumes the FSM value.
- CLEAR:
  - Synchronous; beats TXSTART and TXCLK.
  - Next cycle: state IDLE, SOUT=1 (unless BC), counters 0.
  - No TXFINISHED pulse for the aborted frame.
- RST mid-frame: immediate return to reset values; no TXFINISHED.
- No TXCLK pulses: FSM holds state and SOUT indefinitely.

Test Plan:
- 8N1: WLS=11, PEN=0, STB=0, DIN=0x55, TXSTART. Require:
  - SOUT sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 TXCLK pulses.
  - Frame is 160 pulses total.
  - TXFINISHED pulses once, at pulse 160.
  - BUSY is high throughout.
- 7E1 and 7O1: DIN=0x83, WLS=10, PEN=1. Data 7 bits = 0x03, two ones. Require:
  - EPS=1: parity bit 0.
  - EPS=0: parity bit 1.
  - DIN bit 7 never transmitted.
- Stick parity: WLS=11, PEN=1, SP=1. Require parity bit 0 for EPS=1 and 1 for EPS=0, for both DIN=0x00 and DIN=0xFF.
- Stop lengths:
  - WLS=00, STB=1: frame is 1+5+1.5 bits = 120 TXCLK pulses.
  - WLS=11, STB=1: frame is 176 pulses.
- Back-to-back and ignored start: hold TXSTART high continuously with DIN=0xA5 then 0x3C. Require:
  - Second start bit begins in the cycle after the TXFINISHED pulse.
  - TXSTART during the frame has no effect.
- Break and abort:
  - BC=1 mid-DATA: SOUT=0 immediately; frame length unchanged; TXFINISHED still pulses.
  - CLEAR during PARITY: SOUT=1 and BUSY=0 next cycle, no TXFINISHED.
  - RST asserted asynchronously between CLK edges: SOUT=1 at once.
